// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes, frame constants
// and a helper that turns microseconds into sysclk cycles.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      WAIT_FIRST,
      SHIFT,
      ACK,
      WAIT_IDLE
   } tx_state_e;

   localparam logic [1:0] ERR_NONE          = 2'd0;
   localparam logic [1:0] ERR_START_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_FRAME_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_NO_ACK        = 2'd3;

   localparam int unsigned DATA_BITS   = 8;
   localparam int unsigned FRAME_EDGES = 11;

   function automatic int unsigned cycles_from_us(input int unsigned clk_hz,
                                                  input int unsigned us);
      return (clk_hz / 1_000_000) * us;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the PS/2 clk/dat pads and flags device falling edges on clk.
// sync_clk, sync_dat and fall are registered together so they stay aligned.
module ps2_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic clk_in,
   input  logic dat_in,
   output logic sync_clk,
   output logic sync_dat,
   output logic fall
);

   logic [SYNC_STAGES-1:0] clk_sr;
   logic [SYNC_STAGES-1:0] dat_sr;

   // Chains reset to 1 (idle bus) so reset release never looks like an edge.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sr   <= '1;
         dat_sr   <= '1;
         sync_clk <= 1'b1;
         sync_dat <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_sr   <= {clk_sr[SYNC_STAGES-2:0], clk_in};
         dat_sr   <= {dat_sr[SYNC_STAGES-2:0], dat_in};
         sync_clk <= clk_sr[SYNC_STAGES-1];
         sync_dat <= dat_sr[SYNC_STAGES-1];
         fall     <= sync_clk & ~clk_sr[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, shift one byte out on the
// device clock, check the ACK bit and report done or a coded error.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ           = 50_000_000,
   parameter int unsigned INHIBIT_US       = 100,
   parameter int unsigned START_TIMEOUT_US = 15000,
   parameter int unsigned FRAME_TIMEOUT_US = 2000,
   parameter int unsigned SYNC_STAGES      = 2
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int unsigned INHIBIT_CYC = cycles_from_us(CLK_HZ, INHIBIT_US);
   localparam int unsigned START_CYC   = cycles_from_us(CLK_HZ, START_TIMEOUT_US);
   localparam int unsigned FRAME_CYC   = cycles_from_us(CLK_HZ, FRAME_TIMEOUT_US);
   localparam int unsigned MAX_IS      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
   localparam int unsigned MAX_CYC     = (MAX_IS > FRAME_CYC) ? MAX_IS : FRAME_CYC;
   localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);
   localparam int unsigned IDX_W       = 4;

   logic sync_clk, sync_dat, dev_fall;

   ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .clk_in   (ps2_clk_i),
      .dat_in   (ps2_dat_i),
      .sync_clk (sync_clk),
      .sync_dat (sync_dat),
      .fall     (dev_fall)
   );

   tx_state_e        state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [7:0]       data, data_d;
   logic             parity, parity_d;
   logic [IDX_W-1:0] idx, idx_d;

   logic       drive_en_c, drive_val_c, done_c, err_c;
   logic [1:0] err_code_c;

   logic       clk_oe_d, dat_oe_d, busy_d, tx_ready_d, done_d, err_d;
   logic [1:0] err_code_d;

   // State, datapath and registered outputs.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         data       <= '0;
         parity     <= 1'b0;
         idx        <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         busy       <= 1'b0;
         tx_ready   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         data       <= data_d;
         parity     <= parity_d;
         idx        <= idx_d;
         ps2_clk_oe <= clk_oe_d;
         ps2_dat_oe <= dat_oe_d;
         busy       <= busy_d;
         tx_ready   <= tx_ready_d;
         done       <= done_d;
         err        <= err_d;
         err_code   <= err_code_d;
      end
   end

   // Next state; a device edge takes priority over a same-cycle counter expiry.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      data_d      = data;
      parity_d    = parity;
      idx_d       = idx;
      drive_en_c  = 1'b0;
      drive_val_c = 1'b0;
      done_c      = 1'b0;
      err_c       = 1'b0;
      err_code_c  = ERR_NONE;

      if (state inside {SHIFT, ACK, WAIT_IDLE} && cnt != '0)
         cnt_d = cnt - CNT_W'(1);

      case (state)
         IDLE: begin
            if (tx_valid) begin
               data_d   = tx_data;
               parity_d = ~^tx_data;
               cnt_d    = CNT_W'(INHIBIT_CYC);
               idx_d    = '0;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt == '0) begin
               drive_en_c  = 1'b1;
               drive_val_c = 1'b1;
               state_d     = RTS;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         RTS: begin
            cnt_d   = CNT_W'(START_CYC);
            state_d = WAIT_FIRST;
         end
         WAIT_FIRST: begin
            if (dev_fall) begin
               drive_en_c  = 1'b1;
               drive_val_c = ~data[0];
               idx_d       = IDX_W'(1);
               cnt_d       = CNT_W'(FRAME_CYC);
               state_d     = SHIFT;
            end else if (cnt == '0) begin
               err_c      = 1'b1;
               err_code_c = ERR_START_TIMEOUT;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         SHIFT: begin
            if (dev_fall) begin
               drive_en_c = 1'b1;
               idx_d      = idx + IDX_W'(1);
               if (idx < IDX_W'(DATA_BITS)) begin
                  drive_val_c = ~data[idx[2:0]];
               end else if (idx == IDX_W'(DATA_BITS)) begin
                  drive_val_c = ~parity;
               end else begin
                  drive_val_c = 1'b0;
                  state_d     = ACK;
               end
            end else if (cnt == '0) begin
               err_c      = 1'b1;
               err_code_c = ERR_FRAME_TIMEOUT;
               state_d    = IDLE;
            end
         end
         ACK: begin
            if (dev_fall) begin
               if (!sync_dat) begin
                  state_d = WAIT_IDLE;
               end else begin
                  err_c      = 1'b1;
                  err_code_c = ERR_NO_ACK;
                  state_d    = IDLE;
               end
            end else if (cnt == '0) begin
               err_c      = 1'b1;
               err_code_c = ERR_FRAME_TIMEOUT;
               state_d    = IDLE;
            end
         end
         WAIT_IDLE: begin
            if (sync_clk && sync_dat) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end else if (cnt == '0) begin
               err_c      = 1'b1;
               err_code_c = ERR_FRAME_TIMEOUT;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values for the next cycle, decoded from the state being entered.
   always_comb begin
      clk_oe_d   = (state_d == INHIBIT) || (state_d == RTS);
      dat_oe_d   = ps2_dat_oe;
      if (drive_en_c)
         dat_oe_d = drive_val_c;
      if (state_d == IDLE || state_d == INHIBIT)
         dat_oe_d = 1'b0;
      busy_d     = (state_d != IDLE);
      tx_ready_d = (state_d == IDLE);
      done_d     = done_c;
      err_d      = err_c;
      err_code_d = err_c ? err_code_c : err_code;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the bus.
module tb_ps2_host_tx;

   localparam int unsigned CLK_HZ      = 2_000_000;
   localparam int unsigned INHIBIT_US  = 10;
   localparam int unsigned START_US    = 150;
   localparam int unsigned FRAME_US    = 300;
   localparam int          INHIBIT_CYC = 20;
   localparam int          START_CYC   = 300;
   localparam int          FRAME_CYC   = 600;
   localparam int          HALF        = 10;

   logic       sysclk;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       busy, done, err;
   logic [1:0] err_code;
   logic       dev_clk, dev_dat, dev_active;
   logic       clk_line, dat_line;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, done_busy_bad = 0, clk_viol = 0, hs_cnt = 0;
   int err_cyc = 0, fall_cyc = 0;
   logic [1:0] last_code = 2'd0;

   assign clk_line = dev_clk & ~ps2_clk_oe;
   assign dat_line = dev_dat & ~ps2_dat_oe;

   ps2_host_tx #(
      .CLK_HZ           (CLK_HZ),
      .INHIBIT_US       (INHIBIT_US),
      .START_TIMEOUT_US (START_US),
      .FRAME_TIMEOUT_US (FRAME_US),
      .SYNC_STAGES      (2)
   ) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .ps2_clk_i  (clk_line),
      .ps2_dat_i  (dat_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   always @(posedge sysclk) begin
      cyc <= cyc + 1;
      if (tx_valid && tx_ready) hs_cnt <= hs_cnt + 1;
   end

   always @(negedge sysclk) begin
      if (done) begin
         done_cnt <= done_cnt + 1;
         if (busy) done_busy_bad <= done_busy_bad + 1;
      end
      if (err) begin
         err_cnt   <= err_cnt + 1;
         last_code <= err_code;
         err_cyc   <= cyc;
      end
      if (dev_active && ps2_clk_oe) clk_viol <= clk_viol + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit hold);
      @(negedge sysclk);
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge sysclk);
      chk("tx_ready_drop", 32'(tx_ready), 32'd0);
      chk("busy_rise", 32'(busy), 32'd1);
      if (!hold) tx_valid = 1'b0;
      tx_data = ~b;
   endtask

   // Returns on the first sample after the host releases clk.
   task automatic measure(output int inh, output int rts);
      inh = 0;
      rts = 0;
      for (int n = 0; n < 200; n++) begin
         if (ps2_clk_oe && !ps2_dat_oe) inh++;
         else if (ps2_clk_oe && ps2_dat_oe) rts++;
         else if (inh + rts > 0) break;
         @(negedge sysclk);
      end
   endtask

   task automatic dev_frame(input int n_edges, input bit ack, input int abort_at,
                            output logic [9:0] bits);
      bits = '0;
      dev_active = 1'b1;
      repeat (10) @(negedge sysclk);
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11) dev_dat = ack ? 1'b0 : 1'b1;
         dev_clk = 1'b0;
         if (k == 1) fall_cyc = cyc;
         repeat (HALF) @(negedge sysclk);
         if (k <= 10) bits[k-1] = dat_line;
         if (k == abort_at) begin
            chk("abort_dat_before", 32'(ps2_dat_oe), 32'd1);
            #3 rst_n = 1'b0;
            #1;
            chk("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
            chk("abort_dat_oe", 32'(ps2_dat_oe), 32'd0);
            chk("abort_ready", 32'(tx_ready), 32'd1);
            dev_clk = 1'b1;
            dev_active = 1'b0;
            @(negedge sysclk);
            rst_n = 1'b1;
            return;
         end
         dev_clk = 1'b1;
         repeat (HALF) @(negedge sysclk);
         dev_dat = 1'b1;
      end
      dev_active = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int seen);
      seen = 0;
      for (int n = 0; n < budget; n++) begin
         if (done) begin
            seen = 1;
            tx_valid = 1'b0;
            break;
         end
         @(negedge sysclk);
      end
   endtask

   task automatic wait_err(input int budget, output int n_wait);
      n_wait = -1;
      for (int n = 0; n < budget; n++) begin
         if (err) begin
            n_wait = n;
            break;
         end
         @(negedge sysclk);
      end
   endtask

   int inh, rts, seen, nw, d0, e0, h0;
   logic [9:0] bits;

   initial begin
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      dev_clk = 1'b1; dev_dat = 1'b1; dev_active = 1'b0;
      repeat (3) @(negedge sysclk);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge sysclk);

      // 0xED, device acknowledges
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED, 1'b0);
      measure(inh, rts);
      chk("ed_inhibit_len", 32'(inh >= INHIBIT_CYC - 1 && inh <= INHIBIT_CYC + 1), 32'd1);
      chk("ed_rts_len", 32'(rts), 32'd1);
      chk("ed_start_bit", 32'(ps2_dat_oe), 32'd1);
      dev_frame(11, 1'b1, 0, bits);
      chk("ed_bits", 32'(bits), 32'h3ED);
      wait_done(200, seen);
      chk("ed_done_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge sysclk);
      chk("ed_done_once", 32'(done_cnt - d0), 32'd1);
      chk("ed_no_err", 32'(err_cnt - e0), 32'd0);
      chk("ed_busy_at_done", 32'(done_busy_bad), 32'd0);
      chk("ed_ready_after", 32'(tx_ready), 32'd1);

      // 0x00: parity bit 1
      send(8'h00, 1'b0);
      measure(inh, rts);
      dev_frame(11, 1'b1, 0, bits);
      chk("zero_bits", 32'(bits), 32'h300);
      wait_done(200, seen);
      chk("zero_done_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge sysclk);

      // Device never clocks
      send(8'h5A, 1'b0);
      measure(inh, rts);
      wait_err(START_CYC + 100, nw);
      chk("start_to_window", 32'(nw >= START_CYC - 1 && nw <= START_CYC + 3), 32'd1);
      chk("start_err_code", 32'(err_code), 32'd1);
      chk("start_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("start_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("start_ready", 32'(tx_ready), 32'd1);
      repeat (3) @(negedge sysclk);

      // Device stops after 5 edges
      send(8'hA5, 1'b0);
      measure(inh, rts);
      dev_frame(5, 1'b1, 0, bits);
      wait_err(FRAME_CYC + 100, nw);
      chk("frame_to_seen", 32'(nw >= 0), 32'd1);
      chk("frame_err_code", 32'(err_code), 32'd2);
      chk("frame_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("frame_clk_oe", 32'(ps2_clk_oe), 32'd0);
      repeat (2) @(negedge sysclk);
      chk("frame_to_window", 32'(err_cyc - fall_cyc >= FRAME_CYC && err_cyc - fall_cyc <= FRAME_CYC + 10), 32'd1);

      // Device leaves dat high at edge 11
      d0 = done_cnt; e0 = err_cnt;
      send(8'h3C, 1'b0);
      measure(inh, rts);
      dev_frame(11, 1'b0, 0, bits);
      repeat (40) @(negedge sysclk);
      chk("noack_err_once", 32'(err_cnt - e0), 32'd1);
      chk("noack_code", 32'(last_code), 32'd3);
      chk("noack_err_code_held", 32'(err_code), 32'd3);
      chk("noack_no_done", 32'(done_cnt - d0), 32'd0);

      // Reset in the middle of SHIFT
      send(8'h81, 1'b0);
      measure(inh, rts);
      dev_frame(11, 1'b1, 4, bits);
      repeat (3) @(negedge sysclk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_err_code", 32'(err_code), 32'd0);

      // 0xFF with tx_valid held for the whole frame
      h0 = hs_cnt; d0 = done_cnt;
      send(8'hFF, 1'b1);
      measure(inh, rts);
      dev_frame(11, 1'b1, 0, bits);
      chk("ff_bits", 32'(bits), 32'h3FF);
      wait_done(200, seen);
      chk("ff_done_seen", 32'(seen), 32'd1);
      repeat (30) @(negedge sysclk);
      chk("ff_one_handshake", 32'(hs_cnt - h0), 32'd1);
      chk("ff_done_once", 32'(done_cnt - d0), 32'd1);
      chk("ff_idle_after", 32'(busy), 32'd0);
      chk("clk_never_after_rts", 32'(clk_viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
